// File: rtl/axis_rr_arbiter.sv
// rtl/axis_rr_arbiter.sv - packet-aware round-robin arbiter, N AXI-Stream inputs onto one registered output
module axis_rr_arbiter #(
  parameter int N   = 4,
  parameter int NB  = 40,
  parameter int IDW = $clog2(N)
) (
  input  logic            aclk,
  input  logic            areset,
  input  logic [N*NB-1:0] in_tdata,
  input  logic [N-1:0]    in_tvalid,
  input  logic [N-1:0]    in_tlast,
  output logic [N-1:0]    in_tready,
  output logic [NB-1:0]   out_tdata,
  output logic            out_tlast,
  output logic [IDW-1:0]  out_tid,
  output logic            out_tvalid,
  input  logic            out_tready,
  output logic            busy
);

  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  state_t          r_state;
  logic [IDW-1:0]  r_grant;
  logic [IDW-1:0]  r_ptr;
  logic [NB-1:0]   r_out_tdata;
  logic            r_out_tlast;
  logic [IDW-1:0]  r_out_tid;
  logic            r_out_tvalid;

  logic            w_slot_free;
  logic            w_acc;
  logic            w_found;
  logic [IDW-1:0]  w_pick;
  logic [IDW:0]    w_sum;
  logic [IDW-1:0]  w_ptr_next;
  logic [NB-1:0]   w_ch_data [N];

  always_comb begin
    for (int k = 0; k < N; k++) begin
      w_ch_data[k] = in_tdata[k*NB +: NB];
    end
  end

  assign w_slot_free = ~r_out_tvalid | out_tready;
  assign w_acc       = (r_state == S_GRANT) & w_slot_free & in_tvalid[r_grant];
  assign w_ptr_next  = (r_grant == IDW'(N-1)) ? '0 : r_grant + IDW'(1);

  always_comb begin
    in_tready = '0;
    if (r_state == S_GRANT && w_slot_free) begin
      in_tready[r_grant] = 1'b1;
    end
  end

  // Scan from the highest offset down so the closest requester after ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = '0;
    for (int i = N-1; i >= 0; i--) begin
      w_sum = {1'b0, r_ptr} + (IDW+1)'(i);
      if (w_sum >= (IDW+1)'(N)) begin
        w_sum = w_sum - (IDW+1)'(N);
      end
      if (in_tvalid[w_sum[IDW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_sum[IDW-1:0];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_ptr        <= '0;
      r_out_tdata  <= '0;
      r_out_tlast  <= 1'b0;
      r_out_tid    <= '0;
      r_out_tvalid <= 1'b0;
    end else begin
      if (w_acc) begin
        r_out_tdata  <= w_ch_data[r_grant];
        r_out_tlast  <= in_tlast[r_grant];
        r_out_tid    <= r_grant;
        r_out_tvalid <= 1'b1;
      end else if (r_out_tvalid && out_tready) begin
        r_out_tvalid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= w_pick;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          // Grant is held through valid gaps until the tlast beat is taken.
          if (w_acc && in_tlast[r_grant]) begin
            r_state <= S_IDLE;
            r_ptr   <= w_ptr_next;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_tdata  = r_out_tdata;
  assign out_tlast  = r_out_tlast;
  assign out_tid    = r_out_tid;
  assign out_tvalid = r_out_tvalid;
  assign busy       = (r_state == S_GRANT);

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb/tb_axis_rr_arbiter.sv - scenario bench for axis_rr_arbiter against a packet-level round-robin model
module tb_axis_rr_arbiter;
  localparam int N   = 4;
  localparam int NB  = 40;
  localparam int IDW = $clog2(N);

  logic            aclk = 1'b0;
  logic            areset;
  logic [N*NB-1:0] in_tdata;
  logic [N-1:0]    in_tvalid;
  logic [N-1:0]    in_tlast;
  logic [N-1:0]    in_tready;
  logic [NB-1:0]   out_tdata;
  logic            out_tlast;
  logic [IDW-1:0]  out_tid;
  logic            out_tvalid;
  logic            out_tready;
  logic            busy;

  int errors = 0;
  int checks = 0;

  typedef struct packed {logic [NB-1:0] data; logic last;} beat_t;
  typedef struct packed {logic [IDW-1:0] tid; logic [NB-1:0] data; logic last;} obs_t;

  beat_t        chq [N][$];
  obs_t         exp_q[$];
  obs_t         obs_q[$];
  int           obs_cyc[$];
  logic [N-1:0] tr_log[$];
  int           m_ptr;
  int           bp_start;
  int           bp_len;
  bit           rand_ready;
  bit           rand_gaps;

  axis_rr_arbiter #(.N(N), .NB(NB)) dut (
    .aclk(aclk), .areset(areset),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tlast(out_tlast), .out_tid(out_tid),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .busy(busy)
  );

  always #5 aclk = ~aclk;

  task automatic add_packet(input int ch, input int len);
    beat_t bt;
    for (int b = 0; b < len; b++) begin
      bt.data = {8'(ch), 32'($urandom)};
      bt.last = (b == len - 1);
      chq[ch].push_back(bt);
    end
  endtask

  // Packet-level model: whenever idle, serve the first channel at or after ptr that has a packet.
  task automatic build_expected();
    int idx [N];
    int c;
    bit any;
    bit done;
    obs_t o;
    exp_q.delete();
    idx = '{default: 0};
    any = 1'b1;
    while (any) begin
      any = 1'b0;
      for (int off = 0; off < N && !any; off++) begin
        c = (m_ptr + off) % N;
        if (idx[c] < chq[c].size()) begin
          any  = 1'b1;
          done = 1'b0;
          while (!done) begin
            o.tid  = IDW'(c);
            o.data = chq[c][idx[c]].data;
            o.last = chq[c][idx[c]].last;
            exp_q.push_back(o);
            done = o.last;
            idx[c]++;
          end
          m_ptr = (c + 1) % N;
        end
      end
    end
  endtask

  task automatic do_reset();
    areset     = 1'b1;
    in_tvalid  = '0;
    in_tlast   = '0;
    in_tdata   = '0;
    out_tready = 1'b1;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    m_ptr  = 0;
    for (int k = 0; k < N; k++) chq[k].delete();
  endtask

  task automatic run_traffic(input int max_cyc);
    bit             start [N];
    bit             hold;
    bit             pend;
    logic [NB-1:0]  hd;
    logic [IDW-1:0] ht;
    int             cyc;
    obs_t           o;
    obs_q.delete();
    obs_cyc.delete();
    tr_log.delete();
    start = '{default: 1'b1};
    hold  = 1'b0;
    hd    = '0;
    ht    = '0;
    cyc   = 0;
    build_expected();
    forever begin
      @(negedge aclk);
      pend = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (chq[k].size() > 0) begin
          pend                  = 1'b1;
          in_tvalid[k]          = start[k] | !rand_gaps | ($urandom_range(0, 3) != 0);
          in_tdata[k*NB +: NB]  = chq[k][0].data;
          in_tlast[k]           = chq[k][0].last;
        end else begin
          in_tvalid[k] = 1'b0;
          in_tlast[k]  = 1'b0;
        end
      end
      if (!pend && !out_tvalid && !busy) break;
      if (cyc >= max_cyc) begin
        checks++;
        errors++;
        $display("FAIL timeout: cycles=%0d required below %0d", cyc, max_cyc);
        break;
      end
      out_tready = (cyc >= bp_start && cyc < bp_start + bp_len) ? 1'b0 :
                   (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
      #1;
      checks++;
      if ($countones(in_tready) > 1) begin
        errors++;
        $display("FAIL onehot_ready: in_tready=%b required at most one bit", in_tready);
      end
      if (out_tvalid && !out_tready) begin
        checks++;
        if (in_tready !== '0) begin
          errors++;
          $display("FAIL backpressure_ready: in_tready=%b required 0", in_tready);
        end
      end
      if (hold) begin
        checks++;
        if (out_tvalid !== 1'b1 || out_tdata !== hd || out_tid !== ht) begin
          errors++;
          $display("FAIL stable: valid=%b data=%h tid=%0d required valid=1 data=%h tid=%0d",
                   out_tvalid, out_tdata, out_tid, hd, ht);
        end
      end
      hold = out_tvalid && !out_tready;
      hd   = out_tdata;
      ht   = out_tid;
      tr_log.push_back(in_tready);
      if (out_tvalid && out_tready) begin
        o.tid  = out_tid;
        o.data = out_tdata;
        o.last = out_tlast;
        obs_q.push_back(o);
        obs_cyc.push_back(cyc);
      end
      for (int k = 0; k < N; k++) begin
        if (in_tvalid[k] && in_tready[k]) begin
          start[k] = chq[k][0].last;
          void'(chq[k].pop_front());
        end
      end
      cyc++;
    end
    in_tvalid  = '0;
    in_tlast   = '0;
    out_tready = 1'b1;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL beat_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL beat%0d: got tid=%0d data=%h last=%b required tid=%0d data=%h last=%b", i,
                 obs_q[i].tid, obs_q[i].data, obs_q[i].last, exp_q[i].tid, exp_q[i].data, exp_q[i].last);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks += 6;
    if (out_tvalid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", out_tvalid); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    if (in_tready !== '0)    begin errors++; $display("FAIL reset_ready: got %b required 0", in_tready); end
    if (out_tdata !== '0)    begin errors++; $display("FAIL reset_data: got %h required 0", out_tdata); end
    if (out_tlast !== 1'b0)  begin errors++; $display("FAIL reset_last: got %b required 0", out_tlast); end
    if (out_tid !== '0)      begin errors++; $display("FAIL reset_tid: got %0d required 0", out_tid); end
  endtask

  task automatic test_single_channel();
    do_reset();
    add_packet(2, 3);
    run_traffic(50);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= obs_cyc.size() || obs_cyc[i] != 2 + i) begin
        errors++;
        $display("FAIL single_timing%0d: got cycle %0d required %0d", i,
                 (i < obs_cyc.size()) ? obs_cyc[i] : -1, 2 + i);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    add_packet(2, 1);
    run_traffic(50);
    add_packet(3, 2);
    add_packet(0, 2);
    run_traffic(50);
    checks++;
    if (obs_q.size() < 4 || obs_q[0].tid !== IDW'(3) || obs_q[2].tid !== IDW'(0)) begin
      errors++;
      $display("FAIL wrap_order: got first tids %0d,%0d required 3,0",
               (obs_q.size() > 0) ? int'(obs_q[0].tid) : -1, (obs_q.size() > 2) ? int'(obs_q[2].tid) : -1);
    end
  endtask

  task automatic test_contention();
    logic [N-1:0] exp_tr [6];
    exp_tr = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0100, 4'b0100};
    do_reset();
    add_packet(0, 2);
    add_packet(2, 2);
    run_traffic(50);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= tr_log.size() || tr_log[i] !== exp_tr[i]) begin
        errors++;
        $display("FAIL contention_ready%0d: got %b required %b", i,
                 (i < tr_log.size()) ? tr_log[i] : 4'bxxxx, exp_tr[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    add_packet(1, 5);
    bp_start = 3;
    bp_len   = 3;
    run_traffic(60);
    bp_len = 0;
    for (int i = 3; i < 6; i++) begin
      checks++;
      if (i >= tr_log.size() || tr_log[i] !== '0) begin
        errors++;
        $display("FAIL bp_ready%0d: got %b required 0000", i, (i < tr_log.size()) ? tr_log[i] : 4'bxxxx);
      end
    end
  endtask

  task automatic test_full_rate();
    int j;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < N; k++) add_packet(k, 1);
    end
    run_traffic(100);
    j = 0;
    for (int c = 0; c < tr_log.size(); c++) begin
      if (tr_log[c] !== '0) begin
        checks++;
        if (c != 1 + 2 * j || tr_log[c] !== N'(1 << (j % N))) begin
          errors++;
          $display("FAIL rate_grant%0d: got cycle %0d ready %b required cycle %0d ready %b",
                   j, c, tr_log[c], 1 + 2 * j, N'(1 << (j % N)));
        end
        j++;
      end
    end
    checks++;
    if (j != 3 * N) begin
      errors++;
      $display("FAIL rate_grants: got %0d required %0d", j, 3 * N);
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    add_packet(1, 1);
    run_traffic(50);
    in_tvalid = 4'b0010;
    in_tlast  = '0;
    in_tdata[NB +: NB] = 40'h11_0000_0000;
    @(negedge aclk);
    @(negedge aclk);
    in_tdata[NB +: NB] = 40'h11_0000_0001;
    @(negedge aclk);
    in_tdata[NB +: NB] = 40'h11_0000_0002;
    areset = 1'b1;
    @(negedge aclk);
    areset    = 1'b0;
    in_tvalid = '0;
    #1;
    checks += 3;
    if (out_tvalid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b required 0", out_tvalid); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL midrst_busy: got %b required 0", busy); end
    if (in_tready !== '0)    begin errors++; $display("FAIL midrst_ready: got %b required 0", in_tready); end
    m_ptr = 0;
    add_packet(0, 1);
    add_packet(1, 1);
    add_packet(2, 1);
    run_traffic(50);
    checks++;
    if (obs_q.size() < 1 || obs_q[0].tid !== IDW'(0)) begin
      errors++;
      $display("FAIL midrst_order: got first tid %0d required 0", (obs_q.size() > 0) ? int'(obs_q[0].tid) : -1);
    end
  endtask

  task automatic test_random();
    rand_ready = 1'b1;
    rand_gaps  = 1'b1;
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < N; k++) begin
        for (int p = $urandom_range(0, 3); p > 0; p--) add_packet(k, $urandom_range(1, 4));
      end
      run_traffic(2000);
    end
    rand_ready = 1'b0;
    rand_gaps  = 1'b0;
  endtask

  initial begin
    areset     = 1'b1;
    in_tvalid  = '0;
    in_tlast   = '0;
    in_tdata   = '0;
    out_tready = 1'b1;
    bp_start   = 0;
    bp_len     = 0;
    rand_ready = 1'b0;
    rand_gaps  = 1'b0;
    m_ptr      = 0;
    test_reset();
    test_single_channel();
    test_wrap();
    test_contention();
    test_backpressure();
    test_full_rate();
    test_reset_mid_packet();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
